rf_wb_arbiter: RTL

Shares the single register-file write port between the in-order pipeline writeback (WB) and a multi-cycle unit such as mul/div. Pipeline writes always win. Multi-cycle results wait in a small FIFO and drain on idle WB cycles. The block also exports a pending-write mask for hazard stalls, squashes queued results that a younger pipeline write overtakes, and requests a stall when a queued result starves.

---
 rtl/rf_arb_pkg.sv | 31 +++
 rtl/rf_arb_fifo.sv | 108 ++++++++++
 rtl/rf_wb_arbiter.sv | 128 ++++++++++++
 3 files changed

// File: rtl/rf_arb_pkg.sv
// ============================================================================
// Module : rf_arb_pkg
// Brief  : Shared types and default widths for the register-file write arbiter.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rf_arb_pkg;

    localparam int c_AW = 5;
    localparam int c_DW = 32;

    typedef struct packed {
        logic            we;
        logic [c_AW-1:0] addr;
        logic [c_DW-1:0] data;
    } wb_req_t;

    typedef struct packed {
        logic [c_AW-1:0] addr;
        logic [c_DW-1:0] data;
        logic            kill;
    } fifo_entry_t;

    function automatic logic [31:0] addr_onehot(input logic [c_AW-1:0] a);
        return 32'd1 << a;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rf_arb_fifo.sv
// ============================================================================
// Module : rf_arb_fifo
// Brief  : Multi-cycle result queue with per-entry kill flags and squash compare.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rf_arb_fifo
    import rf_arb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          i_push,
    input  logic [c_AW-1:0]               i_push_addr,
    input  logic [c_DW-1:0]               i_push_data,
    input  logic                          i_pop,
    input  logic                          i_squash,
    input  logic [c_AW-1:0]               i_squash_addr,
    output logic                          o_full,
    output logic                          o_empty,
    output logic [$clog2(DEPTH):0]        o_count,
    output fifo_entry_t                   o_head,
    output fifo_entry_t [DEPTH-1:0]       o_entry,
    output logic [DEPTH-1:0]              o_occupied
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW-1:0] c_PTR_ONE  = PW'(1);
    localparam logic [PW:0]   c_CNT_ONE  = (PW+1)'(1);
    localparam logic [PW:0]   c_CNT_FULL = (PW+1)'(DEPTH);

    logic [c_AW-1:0]  r_addr [DEPTH];
    logic [c_DW-1:0]  r_data [DEPTH];
    logic [DEPTH-1:0] r_kill;
    logic [PW-1:0]    r_rd_ptr;
    logic [PW-1:0]    r_wr_ptr;
    logic [PW:0]      r_count;
    logic [DEPTH-1:0] w_occ;

    // A slot is occupied when its distance from the read pointer is below the count.
    always_comb begin
        logic [PW-1:0] v_off;
        w_occ = '0;
        v_off = '0;
        for (int i = 0; i < DEPTH; i++) begin
            v_off    = PW'(i) - r_rd_ptr;
            w_occ[i] = ({1'b0, v_off} < r_count);
        end
    end

    always_ff @(posedge clk) begin
        if (i_push) begin
            r_addr[r_wr_ptr] <= i_push_addr;
            r_data[r_wr_ptr] <= i_push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_kill <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (i_push && (r_wr_ptr == PW'(i))) begin
                    r_kill[i] <= 1'b0;
                end else if (i_squash && w_occ[i] && (r_addr[i] == i_squash_addr)) begin
                    r_kill[i] <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    generate
        for (genvar g = 0; g < DEPTH; g++) begin : g_entry
            assign o_entry[g] = '{addr: r_addr[g], data: r_data[g], kill: r_kill[g]};
        end
    endgenerate

    assign o_head     = '{addr: r_addr[r_rd_ptr], data: r_data[r_rd_ptr], kill: r_kill[r_rd_ptr]};
    assign o_full     = (r_count == c_CNT_FULL);
    assign o_empty    = (r_count == '0);
    assign o_count    = r_count;
    assign o_occupied = w_occ;

endmodule

`default_nettype wire

// File: rtl/rf_wb_arbiter.sv
// ============================================================================
// Module : rf_wb_arbiter
// Brief  : Register-file write-port arbiter between pipeline WB and a queued
//          multi-cycle unit, with squash, pending mask and starvation stall.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rf_wb_arbiter
    import rf_arb_pkg::*;
#(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4,
    parameter int AW           = c_AW,
    parameter int DW           = c_DW
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   pipe_we,
    input  logic [AW-1:0]          pipe_waddr,
    input  logic [DW-1:0]          pipe_wdata,
    input  logic                   mc_valid,
    output logic                   mc_ready,
    input  logic [AW-1:0]          mc_waddr,
    input  logic [DW-1:0]          mc_wdata,
    output logic                   rf_we,
    output logic [AW-1:0]          rf_waddr,
    output logic [DW-1:0]          rf_wdata,
    output logic [31:0]            pending_mask,
    output logic                   stall_req,
    output logic [$clog2(DEPTH):0] fifo_count
);

    localparam int c_SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [c_SW-1:0] c_STARVE_MAX = c_SW'(STARVE_LIMIT);
    localparam logic [c_SW-1:0] c_STARVE_ONE = c_SW'(1);

    logic                    r_live;
    logic [c_SW-1:0]         r_starve;
    logic                    w_full;
    logic                    w_empty;
    logic                    w_pipe_ok;
    logic                    w_head_live;
    logic                    w_pop;
    logic                    w_push;
    logic [DEPTH-1:0]        w_occ;
    fifo_entry_t             w_head;
    fifo_entry_t [DEPTH-1:0] w_entry;
    wb_req_t                 w_sel;
    logic [31:0]             w_mask;

    // Holds the write port and the accept handshake off until the first clock after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_live <= 1'b0;
        end else begin
            r_live <= 1'b1;
        end
    end

    assign w_pipe_ok   = r_live && pipe_we && (pipe_waddr != '0);
    assign w_head_live = !w_empty && !w_head.kill;
    assign w_pop       = !w_empty && (w_head.kill || !w_pipe_ok);
    assign mc_ready    = r_live && !w_full;

    // r0 results and results overtaken by a same-cycle pipeline write are dropped.
    assign w_push = mc_valid && mc_ready && (mc_waddr != '0)
                 && !(w_pipe_ok && (mc_waddr == pipe_waddr));

    rf_arb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_push        (w_push),
        .i_push_addr   (mc_waddr),
        .i_push_data   (mc_wdata),
        .i_pop         (w_pop),
        .i_squash      (w_pipe_ok),
        .i_squash_addr (pipe_waddr),
        .o_full        (w_full),
        .o_empty       (w_empty),
        .o_count       (fifo_count),
        .o_head        (w_head),
        .o_entry       (w_entry),
        .o_occupied    (w_occ)
    );

    always_comb begin
        w_sel = '0;
        if (w_pipe_ok) begin
            w_sel = '{we: 1'b1, addr: pipe_waddr, data: pipe_wdata};
        end else if (w_head_live) begin
            w_sel = '{we: 1'b1, addr: w_head.addr, data: w_head.data};
        end
    end

    assign rf_we    = w_sel.we;
    assign rf_waddr = w_sel.addr;
    assign rf_wdata = w_sel.data;

    always_comb begin
        w_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_occ[i] && !w_entry[i].kill) begin
                w_mask = w_mask | addr_onehot(w_entry[i].addr);
            end
        end
    end

    assign pending_mask = w_mask;

    // Counts cycles a live head is held off by the pipeline; saturates at the limit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_starve <= '0;
        end else if (w_empty || w_pop) begin
            r_starve <= '0;
        end else if (w_head_live && (r_starve != c_STARVE_MAX)) begin
            r_starve <= r_starve + c_STARVE_ONE;
        end
    end

    assign stall_req = (r_starve == c_STARVE_MAX);

endmodule

`default_nettype wire
